fifo_byte_pixel_packer: RTL and testbench
=========================================

# fifo_byte_pixel_packer

Read-side consumer of the 8-in/8-out video FIFO, running in the FIFO read-clock domain. It pulls bytes from the FIFO whenever it can absorb them and assembles every BYTES_PER_PIX consecutive bytes into one pixel word. Pixels are presented on a valid/ready stream with start-of-frame and end-of-line markers, and feed the downstream video processing stages.

## Interface
- BYTES_PER_PIX, 3: bytes per pixel; legal values 1–4.
- H_ACTIVE, 1280: pixels per line; legal values 2–4095.
- V_ACTIVE, 720: lines per frame; legal values 2–4095.
- rd_clk  in  1  FIFO read clock; the only clock in this block.
- rd_rst  in  1  reset, asynchronous, active-high.
- soft_clr  in  1  synchronous flush and resync, active-high.
- fifo_rd_data  in  8  FIFO read data; valid the cycle after fifo_rd_en (FIFO has no output register).
- fifo_rd_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read enable; drives both rd_en and the read clock enable.
- pix_data  out  8*BYTES_PER_PIX  assembled pixel.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts.
- pix_sof  out  1  qualifies pix_data; first pixel of frame (h=0, v=0).
- pix_eol  out  1  qualifies pix_data; last pixel of line (h=H_ACTIVE-1).

## Operation
- Issue counter issue_idx (0..BYTES_PER_PIX-1) counts bytes as they are requested.
  - It increments on every fifo_rd_en and wraps to 0 after BYTES_PER_PIX-1.
- Landing register rd_en_d = fifo_rd_en delayed by one cycle.
  - When rd_en_d=1, fifo_rd_data is shifted into the assembly register.
  - On the byte that completes a pixel, the full word is pushed into a 2-entry output buffer.
- Credit rule:
  - fifo_rd_en = !fifo_rd_empty && !soft_clr && (issue_idx != BYTES_PER_PIX-1 || free >= 1).
  - free = 2 - occupancy - (rd_en_d && landing byte completes a pixel).
  - Pops in the current cycle are not counted (conservative).
- The output buffer never overflows. The bench flags any push into a full buffer as an error.
- pix_valid = (occupancy != 0). pix_data comes from the head entry.
- A pixel is accepted when pix_valid && pix_ready.
  - h_cnt increments on each accepted pixel.
  - At H_ACTIVE-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 after V_ACTIVE-1.
- pix_sof and pix_eol are decoded from h_cnt/v_cnt for the head pixel and are held while it is stalled.
- soft_clr, for one cycle:
  - Empties the output buffer.
  - Clears issue_idx, the assembly register, rd_en_d, h_cnt and v_cnt.
  - Discards any byte landing in the same cycle.
  - Forces fifo_rd_en=0.
  - A pixel presented during soft_clr is dropped, whatever pix_ready is.
- When fifo_rd_empty=1, no read is issued. A partially assembled pixel stays pending indefinitely.

## Timing
- Reset values:
  - fifo_rd_en=0, pix_valid=0, pix_data=0, pix_sof=0, pix_eol=0.
  - Internal counters and buffer cleared.
- Latency: the last byte's fifo_rd_en at cycle t gives pix_valid=1 at cycle t+2 when the buffer was empty.
- Throughput:
  - One byte per cycle with a non-empty FIFO and pix_ready held high.
  - One pixel per BYTES_PER_PIX cycles with no bubbles.
- Stall: pix_data, pix_sof and pix_eol hold stable while pix_valid && !pix_ready.
- rd_rst asserted mid-frame: all outputs return to reset values immediately. A FIFO read in flight is lost.

## Configuration
- PIX_BYTE_SWAP_EN, undefined: the first byte read lands in the most significant byte of pix_data (R of RGB888).
- PIX_BYTE_SWAP_EN, defined: the first byte read lands in pix_data[7:0].

## Structure
- Package pix_pkg holds:
  - Counter widths derived from H_ACTIVE and V_ACTIVE ($clog2).
  - The pixel word width function.
  - The output buffer depth constant (2).
- Sub-module pix_skid_buf: 2-entry buffer with occupancy output, push/pop interface, sof/eol sideband.

## Test plan
- BYTES_PER_PIX=3, FIFO preloaded with 0x11,0x22,0x33, pix_ready=1 -> pix_data=0x112233, pix_sof=1 two cycles after the third fifo_rd_en. With PIX_BYTE_SWAP_EN defined -> 0x332211.
- H_ACTIVE=4, V_ACTIVE=2, 8 pixels streamed continuously -> pix_eol on pixels 3 and 7, pix_sof on pixel 0 only; the 9th pixel carries pix_sof again.
- pix_ready held 0 for 20 cycles with a full FIFO -> at most 2 pixels buffered, fifo_rd_en stops, no byte lost; after release the pixel sequence is contiguous.
- FIFO empties after 2 bytes of a pixel, refilled 10 cycles later -> the pixel completes correctly from bytes 1–2 plus the new byte 3.
- soft_clr asserted while a byte is landing and one pixel is buffered -> pix_valid=0 next cycle. The next 3 bytes form the pixel with pix_sof=1.
- rd_rst pulsed mid-line -> all outputs 0 asynchronously. After release, h_cnt and v_cnt restart at 0.

Source files
------------

// File: rtl/pix_pkg.sv
// rtl/pix_pkg.sv - shared widths and constants for the byte-to-pixel packer
package pix_pkg;

    localparam int PIX_BUF_DEPTH = 2;

    function automatic int pix_width(input int bytes_per_pix);
        return 8 * bytes_per_pix;
    endfunction

    // Counter width for a count range of n (0..n-1), never narrower than 1 bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_byte_pixel_packer_if.sv
// rtl/fifo_byte_pixel_packer_if.sv - FIFO read side and pixel stream bundle
interface fifo_byte_pixel_packer_if #(
    parameter int BYTES_PER_PIX = 3
);
    localparam int PIX_W = pix_pkg::pix_width(BYTES_PER_PIX);

    logic             soft_clr;
    logic [7:0]       fifo_rd_data;
    logic             fifo_rd_empty;
    logic             fifo_rd_en;
    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_sof;
    logic             pix_eol;

    modport master (
        input  soft_clr, fifo_rd_data, fifo_rd_empty, pix_ready,
        output fifo_rd_en, pix_data, pix_valid, pix_sof, pix_eol
    );

    modport slave (
        output soft_clr, fifo_rd_data, fifo_rd_empty, pix_ready,
        input  fifo_rd_en, pix_data, pix_valid, pix_sof, pix_eol
    );
endinterface

// File: rtl/pix_skid_buf.sv
// rtl/pix_skid_buf.sv - 2-entry pixel output buffer with occupancy and flush
module pix_skid_buf
    import pix_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_occ
);
    logic [W-1:0] r_mem [PIX_BUF_DEPTH];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_occ;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < PIX_BUF_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else if (i_clr) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) r_rd_ptr <= ~r_rd_ptr;
            r_occ <= r_occ + 2'(i_push) - 2'(i_pop);
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;
endmodule

// File: rtl/fifo_byte_pixel_packer.sv
// rtl/fifo_byte_pixel_packer.sv - packs FIFO bytes into pixels with sof/eol framing
// PIX_BYTE_SWAP_EN: when defined the first byte read lands in pix_data[7:0].
module fifo_byte_pixel_packer
    import pix_pkg::*;
#(
    parameter int BYTES_PER_PIX = 3,
    parameter int H_ACTIVE      = 1280,
    parameter int V_ACTIVE      = 720
) (
    input  logic                      i_rd_clk,
    input  logic                      i_rd_rst,
    fifo_byte_pixel_packer_if.master  io_bus
);
    localparam int PIX_W = pix_width(BYTES_PER_PIX);
    localparam int HW    = cnt_width(H_ACTIVE);
    localparam int VW    = cnt_width(V_ACTIVE);
    localparam logic [1:0]    LAST_IDX = 2'(BYTES_PER_PIX - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_ACTIVE - 1);

    logic [1:0]       r_issue_idx;
    logic [1:0]       r_land_idx;
    logic             r_rd_en_d;
    logic [PIX_W-1:0] r_asm;
    logic [HW-1:0]    r_h_cnt;
    logic [VW-1:0]    r_v_cnt;

    logic             w_clr;
    logic             w_land_last;
    logic             w_credit;
    logic             w_rd_en;
    logic             w_push;
    logic             w_pop;
    logic             w_valid;
    logic [1:0]       w_occ;
    logic [PIX_W-1:0] w_head;
    logic [PIX_W-1:0] w_byte;
    logic [PIX_W-1:0] w_asm_next;

    assign w_clr       = io_bus.soft_clr;
    assign w_land_last = r_rd_en_d && (r_land_idx == LAST_IDX);
    // Only the closing byte of a pixel needs a free slot; pops this cycle are ignored
    assign w_credit    = ({1'b0, w_occ} + 3'(w_land_last)) <= 3'd1;
    assign w_rd_en     = !i_rd_rst && !io_bus.fifo_rd_empty && !w_clr &&
                         ((r_issue_idx != LAST_IDX) || w_credit);
    assign w_push      = w_land_last && !w_clr;
    assign w_valid     = (w_occ != 2'd0);
    assign w_pop       = w_valid && io_bus.pix_ready && !w_clr;
    assign w_byte      = PIX_W'(io_bus.fifo_rd_data);

`ifdef PIX_BYTE_SWAP_EN
    assign w_asm_next  = (r_asm >> 8) | (w_byte << (PIX_W - 8));
`else
    assign w_asm_next  = (r_asm << 8) | w_byte;
`endif

    always_ff @(posedge i_rd_clk or posedge i_rd_rst) begin
        if (i_rd_rst) begin
            r_issue_idx <= 2'd0;
            r_land_idx  <= 2'd0;
            r_rd_en_d   <= 1'b0;
            r_asm       <= '0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
        end else if (w_clr) begin
            r_issue_idx <= 2'd0;
            r_land_idx  <= 2'd0;
            r_rd_en_d   <= 1'b0;
            r_asm       <= '0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
        end else begin
            r_rd_en_d <= w_rd_en;
            if (w_rd_en) r_issue_idx <= (r_issue_idx == LAST_IDX) ? 2'd0 : r_issue_idx + 2'd1;
            if (r_rd_en_d) begin
                r_asm      <= w_asm_next;
                r_land_idx <= (r_land_idx == LAST_IDX) ? 2'd0 : r_land_idx + 2'd1;
            end
            if (w_pop) begin
                if (r_h_cnt == H_LAST) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
                end else begin
                    r_h_cnt <= r_h_cnt + HW'(1);
                end
            end
        end
    end

    pix_skid_buf #(.W(PIX_W)) u_buf (
        .i_clk       (i_rd_clk),
        .i_rst       (i_rd_rst),
        .i_clr       (w_clr),
        .i_push      (w_push),
        .i_push_data (w_asm_next),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_occ       (w_occ)
    );

    assign io_bus.fifo_rd_en = w_rd_en;
    assign io_bus.pix_valid  = w_valid;
    assign io_bus.pix_data   = w_head;
    assign io_bus.pix_sof    = w_valid && (r_h_cnt == '0) && (r_v_cnt == '0);
    assign io_bus.pix_eol    = w_valid && (r_h_cnt == H_LAST);
endmodule

// File: tb/tb_fifo_byte_pixel_packer.sv
// tb/tb_fifo_byte_pixel_packer.sv - randomized and directed bench with a pixel-stream model
module tb_fifo_byte_pixel_packer;
    localparam int BPP = 3;
    localparam int H   = 4;
    localparam int V   = 2;
    localparam int PW  = 8 * BPP;

    typedef struct {
        logic [PW-1:0] data;
        bit            sof;
        bit            eol;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_byte_pixel_packer_if #(.BYTES_PER_PIX(BPP)) bus();

    fifo_byte_pixel_packer #(
        .BYTES_PER_PIX (BPP),
        .H_ACTIVE      (H),
        .V_ACTIVE      (V)
    ) dut (
        .i_rd_clk (clk),
        .i_rd_rst (rst),
        .io_bus   (bus.master)
    );

    byte unsigned  fifo_q[$];
    byte unsigned  part[$];
    pix_t          exp_q[$];
    pix_t          pend;
    bit            pend_v, rd_s, acc_s, clr_s;
    int            k_pix;
    int            n_checks, n_fail;
    logic [PW-1:0] acc_data [64];
    bit            acc_sof [64];
    bit            acc_eol [64];
    int            acc_n, rd_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [PW-1:0] word3(input byte unsigned a, input byte unsigned b, input byte unsigned c);
`ifdef PIX_BYTE_SWAP_EN
        return {c, b, a};
`else
        return {a, b, c};
`endif
    endfunction

    // Pixel k of a frame sits at h=k%H, v=(k/H)%V; bytes arrive first-to-last
    function automatic pix_t make_pix();
        pix_t p;
        int   h, v;
        p.data = '0;
        for (int i = 0; i < BPP; i++) begin
`ifdef PIX_BYTE_SWAP_EN
            p.data |= PW'(part[i]) << (8 * i);
`else
            p.data |= PW'(part[i]) << (8 * (BPP - 1 - i));
`endif
        end
        h = k_pix % H;
        v = (k_pix / H) % V;
        p.sof = (h == 0) && (v == 0);
        p.eol = (h == H - 1);
        return p;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        part.delete();
        pend_v = 0;
        k_pix  = 0;
        rd_s   = 0;
        acc_s  = 0;
        clr_s  = 0;
    endtask

    task automatic cycle(input bit clr, input bit rdy, input bit starve);
        byte unsigned b;
        @(posedge clk);
        #1;
        if (acc_s) void'(exp_q.pop_front());
        if (pend_v) begin
            exp_q.push_back(pend);
            pend_v = 0;
        end
        if (clr_s) begin
            exp_q.delete();
            part.delete();
            k_pix = 0;
        end
        bus.soft_clr  = clr;
        bus.pix_ready = rdy;
        if (rd_s) begin
            b = (fifo_q.size() != 0) ? fifo_q.pop_front() : 8'h00;
            bus.fifo_rd_data = b;
            if (!clr) begin
                part.push_back(b);
                if (part.size() == BPP) begin
                    pend   = make_pix();
                    pend_v = 1;
                    k_pix++;
                    part.delete();
                end
            end
        end else begin
            bus.fifo_rd_data = 8'($urandom);
        end
        bus.fifo_rd_empty = (fifo_q.size() == 0) || starve;
        @(negedge clk);
        chk("pix_valid", bus.pix_valid, exp_q.size() != 0);
        chk("buf_depth", exp_q.size() <= 2, 1);
        if (exp_q.size() != 0) begin
            chk("pix_data", bus.pix_data, exp_q[0].data);
            chk("pix_sof", bus.pix_sof, exp_q[0].sof);
            chk("pix_eol", bus.pix_eol, exp_q[0].eol);
        end
        if (bus.fifo_rd_empty || clr)
            chk("rd_en_blocked", bus.fifo_rd_en, 0);
        else if (exp_q.size() + int'(pend_v) <= 1)
            chk("rd_en_credit", bus.fifo_rd_en, 1);
        acc_s = bus.pix_valid && rdy && !clr;
        if (acc_s && acc_n < 64) begin
            acc_data[acc_n] = bus.pix_data;
            acc_sof[acc_n]  = bus.pix_sof;
            acc_eol[acc_n]  = bus.pix_eol;
        end
        if (acc_s) acc_n++;
        rd_s = bus.fifo_rd_en;
        if (rd_s) rd_count++;
        clr_s = clr;
    endtask

    task automatic resync();
        cycle(1, 1, 0);
        acc_n    = 0;
        rd_count = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        acc_n    = 0;
        rd_count = 0;
        model_clear();
        bus.soft_clr      = 0;
        bus.pix_ready     = 0;
        bus.fifo_rd_data  = 8'h00;
        bus.fifo_rd_empty = 0;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        chk("rst_valid", bus.pix_valid, 0);
        chk("rst_data", bus.pix_data, 0);
        chk("rst_sof", bus.pix_sof, 0);
        chk("rst_eol", bus.pix_eol, 0);
        bus.fifo_rd_empty = 1;
        rst = 0;

        // First pixel: third read at c2, valid at c4
        fifo_q = '{8'h11, 8'h22, 8'h33};
        repeat (4) cycle(0, 1, 0);
        chk("lat_not_early", bus.pix_valid, 0);
        cycle(0, 1, 0);
        chk("lat_valid", bus.pix_valid, 1);
`ifdef PIX_BYTE_SWAP_EN
        chk("first_data", bus.pix_data, 24'h332211);
`else
        chk("first_data", bus.pix_data, 24'h112233);
`endif
        chk("first_sof", bus.pix_sof, 1);

        // Nine back-to-back pixels across one 4x2 frame and into the next
        for (int i = 0; i < 27; i++) fifo_q.push_back(8'(i));
        resync();
        repeat (29) cycle(0, 1, 0);
        chk("stream_count", acc_n, 9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("stream_sof%0d", i), acc_sof[i], (i == 0) || (i == 8));
            chk($sformatf("stream_eol%0d", i), acc_eol[i], (i == 3) || (i == 7));
        end
        chk("stream_px0", acc_data[0], word3(8'h00, 8'h01, 8'h02));
        chk("stream_px8", acc_data[8], word3(8'h18, 8'h19, 8'h1A));

        // Back-pressure: two pixels plus two bytes, then reads stop
        for (int i = 0; i < 30; i++) fifo_q.push_back(8'(8'h40 + i));
        resync();
        repeat (20) cycle(0, 0, 0);
        chk("stall_reads", rd_count, 8);
        chk("stall_rd_en", bus.fifo_rd_en, 0);
        chk("stall_valid", bus.pix_valid, 1);
        repeat (40) cycle(0, 1, 0);
        chk("stall_count", acc_n, 10);
        chk("stall_px2", acc_data[2], word3(8'h46, 8'h47, 8'h48));
        chk("stall_px9", acc_data[9], word3(8'h5B, 8'h5C, 8'h5D));

        // FIFO runs dry mid-pixel
        fifo_q = '{8'hA1, 8'hA2};
        resync();
        repeat (10) cycle(0, 1, 0);
        chk("dry_valid", bus.pix_valid, 0);
        fifo_q.push_back(8'hA3);
        repeat (4) cycle(0, 1, 0);
        chk("dry_count", acc_n, 1);
        chk("dry_data", acc_data[0], word3(8'hA1, 8'hA2, 8'hA3));
        chk("dry_sof", acc_sof[0], 1);

        // soft_clr with one pixel buffered and a byte landing
        fifo_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        resync();
        repeat (4) cycle(0, 0, 0);
        cycle(1, 1, 0);
        chk("clr_presented", bus.pix_valid, 1);
        acc_n = 0;
        cycle(0, 1, 0);
        chk("clr_valid_after", bus.pix_valid, 0);
        fifo_q = '{8'hC1, 8'hC2, 8'hC3};
        repeat (5) cycle(0, 1, 0);
        chk("clr_count", acc_n, 1);
        chk("clr_data", acc_data[0], word3(8'hC1, 8'hC2, 8'hC3));
        chk("clr_sof", acc_sof[0], 1);

        // Asynchronous reset mid-line
        for (int i = 0; i < 12; i++) fifo_q.push_back(8'(8'h60 + i));
        resync();
        repeat (7) cycle(0, 1, 0);
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("arst_rd_en", bus.fifo_rd_en, 0);
        chk("arst_valid", bus.pix_valid, 0);
        chk("arst_data", bus.pix_data, 0);
        chk("arst_sof", bus.pix_sof, 0);
        chk("arst_eol", bus.pix_eol, 0);
        fifo_q.delete();
        model_clear();
        bus.soft_clr      = 0;
        bus.fifo_rd_empty = 1;
        repeat (2) @(negedge clk);
        rst   = 0;
        acc_n = 0;
        fifo_q = '{8'hD1, 8'hD2, 8'hD3};
        repeat (5) cycle(0, 1, 0);
        chk("arst_count", acc_n, 1);
        chk("arst_data_after", acc_data[0], word3(8'hD1, 8'hD2, 8'hD3));
        chk("arst_sof_after", acc_sof[0], 1);
        chk("arst_eol_after", acc_eol[0], 0);

        // Randomized traffic against the model
        resync();
        for (int c = 0; c < 3000; c++) begin
            if (fifo_q.size() < 6)
                for (int j = 0; j < 4; j++) fifo_q.push_back(8'($urandom));
            cycle($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 15);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
